dfx_data_recv_arbiter: RTL and testbench

//  Shares the write port of the DFX receive FIFO (fifo_dfx_data_recv, 1034-bit entries) between
//  NUM_REQ sources with packet-locked round-robin arbitration. Sequences the FIFO read port into a

---
 rtl/dfx_recv_pkg.sv | 13 +
 rtl/dfx_recv_skid_buf.sv | 62 ++++++
 rtl/dfx_data_recv_arbiter.sv | 137 +++++++++++++
 tb/tb_dfx_data_recv_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfx_recv_pkg.sv
// Shared definitions for the DFX receive path: entry width, last-beat
// marker position and the write-side arbiter state encoding.
package dfx_recv_pkg;

    localparam int DFX_DATA_W   = 1034;
    localparam int DFX_LAST_BIT = 1033;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/dfx_recv_skid_buf.sv
// Two-entry output buffer for beats returning from the receive FIFO.
// Ports: clk, rst_n, in_valid/in_data (FIFO return, never refused),
//   out_valid/out_ready/out_data (downstream), count (entries held).
module dfx_recv_skid_buf
    import dfx_recv_pkg::*;
#(
    parameter int DATA_W = DFX_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        cnt_q;
    logic              pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign count     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            unique case ({in_valid, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // With one entry the incoming beat becomes the new head.
                    if (cnt_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_valid && cnt_q == 2'd2 && !pop));

endmodule

// File: rtl/dfx_data_recv_arbiter.sv
// Packet-locked round-robin arbiter onto the DFX receive FIFO write port,
// with occupancy tracking and read sequencing into a valid/ready stream.
// Ports: clk, rst_n; req_valid/req_data/req_ready (sources);
//   fifo_write_enable/fifo_data_in/fifo_read_enable/fifo_data_out/
//   fifo_empty (FIFO); out_valid/out_data/out_ready (downstream);
//   occupancy (entries accepted and not yet read-issued).
module dfx_data_recv_arbiter
    import dfx_recv_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = DFX_DATA_W,
    parameter int DEPTH    = 16,
    parameter int LAST_BIT = DFX_LAST_BIT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fifo_write_enable,
    output logic [DATA_W-1:0]           fifo_data_in,
    output logic                        fifo_read_enable,
    input  logic [DATA_W-1:0]           fifo_data_out,
    input  logic                        fifo_empty,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              accept;
    logic [DATA_W-1:0] acc_data;
    logic              rd_issue;
    logic              rd_inflight_q;
    logic              pop;
    logic [1:0]        buf_cnt;
    logic [2:0]        pend;

    function automatic logic [PTR_W-1:0] wrap(input int a);
        int b;
        b = (a >= NUM_REQ) ? a - NUM_REQ : a;
        return PTR_W'(b);
    endfunction

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state_q == LOCKED) begin
            grant_vld = 1'b1;
            grant_idx = owner_q;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[wrap(int'(rr_ptr_q) + k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = wrap(int'(rr_ptr_q) + k);
                end
            end
        end
    end

    // rst_n gating keeps the combinational outputs low during reset.
    assign accept = rst_n && grant_vld && req_valid[grant_idx]
                    && (occupancy < OCC_W'(DEPTH));
    assign acc_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (accept) begin
            rr_ptr_d = wrap(int'(grant_idx) + 1);
            if (acc_data[LAST_BIT]) begin
                state_d = IDLE;
            end else begin
                state_d = LOCKED;
                owner_d = grant_idx;
            end
        end
    end

    // Beats already buffered or in flight must leave room for the issue.
    assign pop      = out_valid && out_ready;
    assign pend     = {1'b0, buf_cnt} + {2'b0, rd_inflight_q} - {2'b0, pop};
    assign rd_issue = rst_n && (occupancy != '0) && (pend < 3'd2);
    assign fifo_read_enable = rd_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            rr_ptr_q          <= '0;
            owner_q           <= '0;
            fifo_write_enable <= 1'b0;
            fifo_data_in      <= '0;
            occupancy         <= '0;
            rd_inflight_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            owner_q           <= owner_d;
            fifo_write_enable <= accept;
            if (accept) fifo_data_in <= acc_data;
            rd_inflight_q     <= rd_issue;
            unique case ({accept, rd_issue})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: ;
            endcase
        end
    end

    dfx_recv_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_inflight_q),
        .in_data   (fifo_data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (buf_cnt)
    );

    a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_read_enable && fifo_empty));

endmodule

// File: tb/tb_dfx_data_recv_arbiter.sv
// Scoreboard bench for dfx_data_recv_arbiter with a behavioural FIFO.
module tb_dfx_data_recv_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 1034;
    localparam int LB    = 1033;
    localparam int DEPTH = 16;
    localparam int OW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_write_enable;
    logic [DW-1:0]    fifo_data_in;
    logic             fifo_read_enable;
    logic [DW-1:0]    fifo_data_out;
    logic             fifo_empty;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;
    logic [OW-1:0]    occupancy;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int rd_cnt = 0;
    int src0_offered = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] fmem[$];
    int fcnt = 0;
    logic [DW-1:0] mon_exp;

    dfx_data_recv_arbiter #(
        .NUM_REQ (NR), .DATA_W (DW), .DEPTH (DEPTH), .LAST_BIT (LB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .fifo_write_enable (fifo_write_enable),
        .fifo_data_in      (fifo_data_in),
        .fifo_read_enable  (fifo_read_enable),
        .fifo_data_out     (fifo_data_out),
        .fifo_empty        (fifo_empty),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_ready         (out_ready),
        .occupancy         (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: registered read, write-to-read bypass when empty.
    assign fifo_empty = (fcnt == 0) && !fifo_write_enable;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmem.delete();
            fcnt = 0;
            fifo_data_out <= '0;
        end else if (fifo_read_enable && fifo_write_enable && fcnt == 0) begin
            fifo_data_out <= fifo_data_in;
        end else begin
            if (fifo_read_enable && fcnt != 0) fifo_data_out <= fmem.pop_front();
            if (fifo_write_enable) begin
                tests++;
                if (fmem.size() >= DEPTH) begin
                    fails++;
                    $display("FAIL fifo_overflow: entries=%0d required<%0d", fmem.size(), DEPTH);
                end
                fmem.push_back(fifo_data_in);
            end
            fcnt = fmem.size();
        end
    end

    // Scoreboard monitor: push on accept, pop and compare on output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_read_enable) rd_cnt++;
            if (req_ready != '0) begin
                tests++;
                if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
                    fails++;
                    $display("FAIL grant_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
                end else begin
                    for (int i = 0; i < NR; i++)
                        if (req_ready[i]) begin
                            sb.push_back(req_data[i*DW +: DW]);
                            acc_cnt++;
                        end
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL out_extra: got beat lo=%h with empty scoreboard", out_data[63:0]);
                end else begin
                    mon_exp = sb.pop_front();
                    if (out_data !== mon_exp) begin
                        fails++;
                        $display("FAIL out_order: got lo=%h last=%b required lo=%h last=%b",
                                 out_data[63:0], out_data[LB], mon_exp[63:0], mon_exp[LB]);
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] make_beat(input logic last);
        logic [DW-1:0] b;
        for (int k = 0; k < DW; k++) b[k] = 1'($urandom_range(0, 1));
        b[LB] = last;
        return b;
    endfunction

    task automatic set_beat(input int i, input logic last);
        req_data[i*DW +: DW] = make_beat(last);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        sb.delete();
        next_cycle();
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if (req_ready !== '0 || fifo_write_enable !== 1'b0 || fifo_data_in !== '0
            || fifo_read_enable !== 1'b0 || out_valid !== 1'b0 || out_data !== '0
            || occupancy !== '0) begin
            fails++;
            $display("FAIL %s: rdy=%b we=%b din_lo=%h re=%b ov=%b od_lo=%h occ=%0d required all 0",
                     name, req_ready, fifo_write_enable, fifo_data_in[63:0],
                     fifo_read_enable, out_valid, out_data[63:0], occupancy);
        end
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!out_valid && occupancy == '0 && !fifo_write_enable && sb.size() == 0)
                done = 1'b1;
            next_cycle();
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL drain_%s: %0d beats left, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NR; i++) set_beat(i, 1'b0);
        #7;
        check_all_zero("reset_held");
        apply_reset();
        @(negedge clk);
        check_all_zero("reset_released");
        next_cycle();
    endtask

    task automatic test_single_beat();
        logic [DW-1:0] beat;
        beat = make_beat(1'b1);
        req_data[0 +: DW] = beat;
        out_ready = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL single_accept: req_ready=%b required 0001", req_ready);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        tests++;
        if (fifo_write_enable !== 1'b1 || fifo_data_in !== beat || occupancy !== OW'(1)) begin
            fails++;
            $display("FAIL single_write: we=%b din_lo=%h occ=%0d required 1 %h 1",
                     fifo_write_enable, fifo_data_in[63:0], occupancy, beat[63:0]);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || occupancy !== '0) begin
            fails++;
            $display("FAIL single_t2: ov=%b occ=%0d required 0 0", out_valid, occupancy);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== beat) begin
            fails++;
            $display("FAIL single_t3: ov=%b od_lo=%h required 1 %h",
                     out_valid, out_data[63:0], beat[63:0]);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || occupancy !== '0) begin
            fails++;
            $display("FAIL single_t4: ov=%b occ=%0d required 0 0", out_valid, occupancy);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] got;
        int exp_i;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_beat(i, 1'b1);
        req_valid = '1;
        exp_i = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            got = req_ready;
            tests++;
            if (got !== NR'(1 << exp_i)) begin
                fails++;
                $display("FAIL rr_grant_%0d: req_ready=%b required %b", c, got, NR'(1 << exp_i));
            end
            exp_i = (exp_i + 1) % NR;
            next_cycle();
            for (int i = 0; i < NR; i++) if (got[i]) set_beat(i, 1'b1);
        end
        req_valid = '0;
        drain("rr");
    endtask

    task automatic test_packet_lock();
        logic [NR-1:0] exp_g [5];
        exp_g = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
        apply_reset();
        out_ready = 1'b1;
        set_beat(2, 1'b1);
        set_beat(1, 1'b0);
        req_valid = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (req_ready !== exp_g[c]) begin
                fails++;
                $display("FAIL lock_step_%0d: req_ready=%b required %b", c, req_ready, exp_g[c]);
            end
            next_cycle();
            unique case (c)
                0: req_valid[1] = 1'b0;
                1: begin set_beat(1, 1'b0); req_valid[1] = 1'b1; end
                2: set_beat(1, 1'b1);
                3: req_valid[1] = 1'b0;
                default: req_valid = '0;
            endcase
        end
        drain("lock");
    endtask

    task automatic test_fill();
        int accepted;
        int rd0;
        logic got;
        apply_reset();
        out_ready = 1'b0;
        accepted = 0;
        src0_offered = 0;
        rd0 = rd_cnt;
        set_beat(0, 1'b1);
        req_valid = 4'b0001;
        repeat (40) begin
            @(negedge clk);
            got = req_ready[0];
            next_cycle();
            if (got) begin
                accepted++;
                src0_offered++;
                if (src0_offered < 20) set_beat(0, 1'b1);
                else req_valid = '0;
            end
        end
        tests++;
        if (rd_cnt - rd0 != 2) begin
            fails++;
            $display("FAIL fill_reads: reads=%0d required 2", rd_cnt - rd0);
        end
        @(negedge clk);
        tests++;
        if (accepted != 18) begin
            fails++;
            $display("FAIL fill_accepted: accepted=%0d required 18", accepted);
        end
        tests++;
        if (req_ready !== '0 || occupancy !== OW'(DEPTH) || out_valid !== 1'b1
            || fifo_read_enable !== 1'b0) begin
            fails++;
            $display("FAIL fill_state: rdy=%b occ=%0d ov=%b re=%b required 0000 16 1 0",
                     req_ready, occupancy, out_valid, fifo_read_enable);
        end
        next_cycle();
    endtask

    task automatic test_full_read_write();
        int acc0;
        int rd0;
        logic got;
        acc0 = acc_cnt;
        rd0 = rd_cnt;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            got = req_ready[0];
            next_cycle();
            out_ready = 1'b0;
            if (got) begin
                src0_offered++;
                if (src0_offered < 20) set_beat(0, 1'b1);
                else req_valid = '0;
            end
        end
        tests++;
        if (acc_cnt - acc0 != 1 || rd_cnt - rd0 != 1) begin
            fails++;
            $display("FAIL full_rw_counts: accepts=%0d reads=%0d required 1 1",
                     acc_cnt - acc0, rd_cnt - rd0);
        end
        @(negedge clk);
        tests++;
        if (occupancy !== OW'(DEPTH) || req_ready !== '0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL full_rw_state: occ=%0d rdy=%b ov=%b required 16 0000 1",
                     occupancy, req_ready, out_valid);
        end
        next_cycle();
        req_valid = '0;
        drain("full");
    endtask

    task automatic test_reset_mid_packet();
        logic [NR-1:0] exp_g [3];
        logic [NR-1:0] got;
        exp_g = '{4'b0001, 4'b0010, 4'b1000};
        apply_reset();
        out_ready = 1'b0;
        set_beat(3, 1'b0);
        req_valid = 4'b1000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if (req_ready !== 4'b1000) begin
                fails++;
                $display("FAIL locked_owner_%0d: req_ready=%b required 1000", c, req_ready);
            end
            next_cycle();
            set_beat(3, 1'b0);
            if (c == 0) begin
                set_beat(0, 1'b1);
                set_beat(1, 1'b1);
                req_valid = 4'b1011;
            end
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || occupancy === '0) begin
            fails++;
            $display("FAIL pre_reset: ov=%b occ=%0d required 1 nonzero", out_valid, occupancy);
        end
        next_cycle();
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_packet");
        sb.delete();
        set_beat(3, 1'b1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = req_ready;
            tests++;
            if (got !== exp_g[c]) begin
                fails++;
                $display("FAIL restart_grant_%0d: req_ready=%b required %b", c, got, exp_g[c]);
            end
            next_cycle();
            req_valid = req_valid & ~got;
        end
        req_valid = '0;
        drain("restart");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_packet_lock();
        test_fill();
        test_full_read_write();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
